aes_byte_loader: RTL

AES_BYTE_LOADER -- requirements
Module: aes_byte_loader

---
 rtl/aes_byte_loader_if.sv | 22 ++
 rtl/aes_byte_loader.sv | 96 +++++++++
 2 files changed

// File: rtl/aes_byte_loader_if.sv
// Byte-serial load channel into the AES loader: one byte per accepted cycle,
// with the frame type carried on key_sel alongside the first byte.
interface aes_byte_loader_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic       key_sel;

   modport master (
      output byte_in,
      output byte_valid,
      output key_sel,
      input  byte_ready
   );

   modport slave (
      input  byte_in,
      input  byte_valid,
      input  key_sel,
      output byte_ready
   );
endinterface

// File: rtl/aes_byte_loader.sv
// Assembles 16-byte frames into the AES key or plaintext block and tracks
// presented blocks through a fixed-latency pipe to flag when dataout is valid.
module aes_byte_loader #(
   parameter int LATENCY = 10
) (
   input  logic             clk,
   input  logic             rst,
   aes_byte_loader_if.slave bus,
   output logic [127:0]     datain,
   output logic [127:0]     key,
   output logic             key_loaded,
   output logic             block_valid,
   output logic             out_valid,
   output logic             frame_err,
   output logic [3:0]       byte_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, ISSUE} state_t;

   state_t               state;
   state_t               next_state;
   logic                 ready;
   logic                 accept;
   logic                 frame_key;
   logic [127:0]         assembly;
   logic [LATENCY-1:0]   in_flight;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.byte_valid) next_state = SHIFT;
         end
         SHIFT: begin
            ready = 1'b1;
            if (bus.byte_valid && byte_cnt == 4'd15) next_state = ISSUE;
         end
         ISSUE:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
      // Nothing may be accepted while reset is held.
      if (rst) ready = 1'b0;
   end

   assign accept         = ready && bus.byte_valid;
   assign bus.byte_ready = ready;
   assign out_valid      = in_flight[LATENCY-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         assembly    <= '0;
         frame_key   <= 1'b0;
         byte_cnt    <= '0;
         datain      <= '0;
         key         <= '0;
         key_loaded  <= 1'b0;
         block_valid <= 1'b0;
         frame_err   <= 1'b0;
         in_flight   <= '0;
      end else begin
         block_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (accept) begin
            if (state == IDLE) begin
               assembly  <= {120'd0, bus.byte_in};
               frame_key <= bus.key_sel;
               byte_cnt  <= 4'd1;
            end else begin
               assembly <= {assembly[119:0], bus.byte_in};
               byte_cnt <= byte_cnt + 4'd1;
            end
         end
         // A data frame is only useful once a key exists; otherwise it is dropped and flagged.
         if (state == ISSUE) begin
            if (frame_key) begin
               key        <= assembly;
               key_loaded <= 1'b1;
            end else if (key_loaded) begin
               datain      <= assembly;
               block_valid <= 1'b1;
            end else begin
               frame_err <= 1'b1;
            end
         end
         in_flight <= (in_flight << 1) | LATENCY'(block_valid);
      end
   end

endmodule
